// File: rtl/rtc_bus_arbiter.sv
// Two-requester round-robin arbiter driving a multiplexed RTC bus.
// Each transaction runs an address phase, a turnaround, a data phase and a
// trailing hold. Each of those four phases lasts T_PH clocks. A one-cycle
// DONE state follows before the arbiter returns to IDLE.
module rtc_bus_arbiter #(
    parameter int T_PH = 4,
    parameter int N    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req,
    input  logic [1:0]     we,
    input  logic [2*N-1:0] addr,
    input  logic [2*N-1:0] wdata,
    output logic [1:0]     gnt,
    output logic           done,
    output logic [N-1:0]   rdata,
    output logic           busy,
    output logic           AD,
    output logic           CS,
    output logic           WR,
    output logic           RD,
    output logic [N-1:0]   bus_out,
    output logic           bus_oe,
    input  logic [N-1:0]   bus_in
);

    typedef enum logic [2:0] {
        IDLE,
        ADR,
        ADR_H,
        DAT,
        DAT_H,
        DONE
    } state_t;

    localparam logic [3:0] PH_LAST = 4'(T_PH - 1);

    state_t         state;
    state_t         state_next;
    logic [3:0]     cnt;
    logic [3:0]     cnt_next;
    logic           ph_end;
    logic           sel;
    logic           last;
    logic           we_l;
    logic [N-1:0]   addr_l;
    logic [N-1:0]   wdata_l;

    assign ph_end = (cnt == PH_LAST);

    // Round-robin pick: on contention the requester not granted last wins
    always_comb begin
        if (req == 2'b11) begin
            sel = ~last;
        end else begin
            sel = req[1];
        end
    end

    // State and phase counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state sequencing and bus strobe decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        AD         = 1'b1;
        CS         = 1'b1;
        WR         = 1'b1;
        RD         = 1'b1;
        bus_oe     = 1'b0;
        bus_out    = '0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_next = ADR;
                    cnt_next   = '0;
                end
            end
            ADR: begin
                AD      = 1'b0;
                CS      = 1'b0;
                WR      = 1'b0;
                bus_oe  = 1'b1;
                bus_out = addr_l;
                if (ph_end) begin
                    state_next = ADR_H;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ADR_H: begin
                if (ph_end) begin
                    state_next = DAT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DAT: begin
                CS = 1'b0;
                if (we_l) begin
                    WR      = 1'b0;
                    bus_oe  = 1'b1;
                    bus_out = wdata_l;
                end else begin
                    RD = 1'b0;
                end
                if (ph_end) begin
                    state_next = DAT_H;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DAT_H: begin
                if (ph_end) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    // Grant, transaction latches, round-robin history and read capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt     <= '0;
            last    <= 1'b1;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && (|req)) begin
                gnt     <= sel ? 2'b10 : 2'b01;
                last    <= sel;
                we_l    <= we[sel];
                addr_l  <= sel ? addr[2*N-1:N] : addr[N-1:0];
                wdata_l <= sel ? wdata[2*N-1:N] : wdata[N-1:0];
            end else if (state == DONE) begin
                gnt <= '0;
            end
            if (state == DAT && ph_end && !we_l) begin
                rdata <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: one instance at T_PH=4 and one at T_PH=1.
module tb_rtc_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic        done;
    logic [7:0]  rdata;
    logic        busy;
    logic        AD, CS, WR, RD;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  bus_in;

    logic [1:0]  p1_req;
    logic [1:0]  p1_we;
    logic [15:0] p1_addr;
    logic [15:0] p1_wdata;
    logic [1:0]  p1_gnt;
    logic        p1_done;
    logic [7:0]  p1_rdata;
    logic        p1_busy;
    logic        p1_AD, p1_CS, p1_WR, p1_RD;
    logic [7:0]  p1_bus_out;
    logic        p1_bus_oe;
    logic [7:0]  p1_bus_in;

    int tests;
    int fails;

    rtc_bus_arbiter #(.T_PH(4), .N(8)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .AD(AD), .CS(CS), .WR(WR), .RD(RD),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    rtc_bus_arbiter #(.T_PH(1), .N(8)) u_dut1 (
        .clk(clk), .reset(reset), .req(p1_req), .we(p1_we), .addr(p1_addr), .wdata(p1_wdata),
        .gnt(p1_gnt), .done(p1_done), .rdata(p1_rdata), .busy(p1_busy),
        .AD(p1_AD), .CS(p1_CS), .WR(p1_WR), .RD(p1_RD),
        .bus_out(p1_bus_out), .bus_oe(p1_bus_oe), .bus_in(p1_bus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 2'b11;
        #2;
        tests++;
        if ({AD, CS, WR, RD, bus_oe} !== 5'b11110 || bus_out !== 8'h00 || gnt !== 2'b00 ||
            done !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: strobes=%b bus_out=%h gnt=%b done=%b busy=%b rdata=%h, required 11110 00 00 0 0 00",
                     {AD, CS, WR, RD, bus_oe}, bus_out, gnt, done, busy, rdata);
        end
        tick();
        tick();
        tests++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_held_clocked: gnt=%b busy=%b, required 00 0", gnt, busy);
        end
        req = 2'b00;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [4:0] exp_s;
        logic [7:0] exp_b;
        req   = 2'b01;
        we    = 2'b01;
        addr  = 16'h0021;
        wdata = 16'h0045;
        tick();
        req = 2'b00;
        tests++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL write_grant: gnt=%b, required 01", gnt);
        end
        for (int c = 0; c < 16; c++) begin
            case (c / 4)
                0:       begin exp_s = 5'b00011; exp_b = 8'h21; end
                2:       begin exp_s = 5'b10011; exp_b = 8'h45; end
                default: begin exp_s = 5'b11110; exp_b = 8'h00; end
            endcase
            tests++;
            if ({AD, CS, WR, RD, bus_oe} !== exp_s || (exp_s[0] && bus_out !== exp_b) ||
                done !== 1'b0 || gnt !== 2'b01) begin
                fails++;
                $display("FAIL write_cycle%0d: strobes=%b bus_out=%h done=%b gnt=%b, required %b %h 0 01",
                         c, {AD, CS, WR, RD, bus_oe}, bus_out, done, gnt, exp_s, exp_b);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || gnt !== 2'b01 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL write_done: done=%b gnt=%b rdata=%h, required 1 01 00", done, gnt, rdata);
        end
        tick();
        tests++;
        if (done !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL write_idle: done=%b gnt=%b busy=%b, required 0 00 0", done, gnt, busy);
        end
    endtask

    task automatic test_addr_hold();
        bit found;
        req   = 2'b01;
        we    = 2'b01;
        addr  = 16'h0021;
        wdata = 16'h0045;
        tick();
        req  = 2'b00;
        addr = 16'h007F;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (AD !== 1'b0 || bus_out !== 8'h21) begin
                fails++;
                $display("FAIL addr_hold_cycle%0d: AD=%b bus_out=%h, required 0 21", c, AD, bus_out);
            end
            tick();
        end
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (done === 1'b1) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL addr_hold_done_timeout: done=%b, required 1", done);
        end
        tick();
    endtask

    task automatic test_read();
        logic [4:0] exp_s;
        bit found;
        req    = 2'b10;
        we     = 2'b00;
        addr   = 16'h3300;
        bus_in = 8'hAA;
        tick();
        req = 2'b00;
        tests++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL read_grant: gnt=%b, required 10", gnt);
        end
        for (int c = 0; c < 16; c++) begin
            if (c == 8)  bus_in = 8'h59;
            if (c == 12) bus_in = 8'hAA;
            case (c / 4)
                0:       exp_s = 5'b00011;
                2:       exp_s = 5'b10100;
                default: exp_s = 5'b11110;
            endcase
            tests++;
            if ({AD, CS, WR, RD, bus_oe} !== exp_s || (c < 4 && bus_out !== 8'h33)) begin
                fails++;
                $display("FAIL read_cycle%0d: strobes=%b bus_out=%h, required %b (bus 33 in ADR)",
                         c, {AD, CS, WR, RD, bus_oe}, bus_out, exp_s);
            end
            tick();
        end
        tests++;
        if (done !== 1'b1 || rdata !== 8'h59 || gnt !== 2'b10) begin
            fails++;
            $display("FAIL read_done: done=%b rdata=%h gnt=%b, required 1 59 10", done, rdata, gnt);
        end
        tick();
        // A following write must not disturb rdata
        req   = 2'b01;
        we    = 2'b01;
        wdata = 16'h0066;
        tick();
        req = 2'b00;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (done === 1'b1) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found || rdata !== 8'h59) begin
            fails++;
            $display("FAIL write_keeps_rdata: found=%0d rdata=%h, required 1 59", found, rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [4];
        int gaps [4];
        int n;
        int zeros;
        logic [1:0] prev;
        bit idle;
        reset = 1'b0;
        tick();
        req   = 2'b11;
        we    = 2'b11;
        addr  = 16'h2211;
        wdata = 16'hBBAA;
        reset = 1'b1;
        n     = 0;
        zeros = 0;
        prev  = 2'b00;
        for (int k = 0; k < 200 && n < 4; k++) begin
            tick();
            if (gnt !== 2'b00 && prev === 2'b00) begin
                seq[n]  = gnt;
                gaps[n] = zeros;
                n++;
            end
            if (gnt === 2'b00) zeros++;
            else zeros = 0;
            prev = gnt;
        end
        req = 2'b00;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL rr_grant_count: grants=%0d, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || (i > 0 && gaps[i] != 1)) begin
                fails++;
                $display("FAIL rr_grant%0d: gnt=%b gap=%0d, required %b gap 1",
                         i, seq[i], gaps[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            tick();
            if (busy === 1'b0) idle = 1'b1;
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("FAIL rr_idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 2'b01;
        we    = 2'b01;
        addr  = 16'h0021;
        wdata = 16'h0045;
        tick();
        for (int c = 0; c < 9; c++) tick();
        tests++;
        if (WR !== 1'b0 || AD !== 1'b1 || bus_out !== 8'h45) begin
            fails++;
            $display("FAIL mid_in_dat: WR=%b AD=%b bus_out=%h, required 0 1 45", WR, AD, bus_out);
        end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({AD, CS, WR, RD, bus_oe} !== 5'b11110 || gnt !== 2'b00 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort: strobes=%b gnt=%b done=%b busy=%b, required 11110 00 0 0",
                     {AD, CS, WR, RD, bus_oe}, gnt, done, busy);
        end
        tick();
        tests++;
        if (gnt !== 2'b00 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_held: gnt=%b done=%b, required 00 0", gnt, done);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (gnt !== 2'b01 || AD !== 1'b0 || bus_out !== 8'h21) begin
            fails++;
            $display("FAIL mid_restart: gnt=%b AD=%b bus_out=%h, required 01 0 21", gnt, AD, bus_out);
        end
        req = 2'b00;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (done === 1'b1) found = 1'b1;
            else tick();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL mid_done_timeout: done=%b, required 1", done);
        end
        tick();
    endtask

    task automatic test_tph1();
        logic [4:0] exp_s;
        p1_req   = 2'b01;
        p1_we    = 2'b01;
        p1_addr  = 16'h0021;
        p1_wdata = 16'h0045;
        tick();
        p1_req = 2'b00;
        tests++;
        if (p1_gnt !== 2'b01) begin
            fails++;
            $display("FAIL tph1_grant: gnt=%b, required 01", p1_gnt);
        end
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       exp_s = 5'b00011;
                2:       exp_s = 5'b10011;
                default: exp_s = 5'b11110;
            endcase
            tests++;
            if ({p1_AD, p1_CS, p1_WR, p1_RD, p1_bus_oe} !== exp_s || p1_done !== 1'b0 ||
                (c == 0 && p1_bus_out !== 8'h21) || (c == 2 && p1_bus_out !== 8'h45)) begin
                fails++;
                $display("FAIL tph1_cycle%0d: strobes=%b bus_out=%h done=%b, required %b done 0",
                         c, {p1_AD, p1_CS, p1_WR, p1_RD, p1_bus_oe}, p1_bus_out, p1_done, exp_s);
            end
            tick();
        end
        tests++;
        if (p1_done !== 1'b1 || p1_gnt !== 2'b01) begin
            fails++;
            $display("FAIL tph1_done: done=%b gnt=%b, required 1 01", p1_done, p1_gnt);
        end
        tick();
        tests++;
        if (p1_done !== 1'b0 || p1_gnt !== 2'b00) begin
            fails++;
            $display("FAIL tph1_idle: done=%b gnt=%b, required 0 00", p1_done, p1_gnt);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        req       = 2'b00;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;
        bus_in    = '0;
        p1_req    = 2'b00;
        p1_we     = 2'b00;
        p1_addr   = '0;
        p1_wdata  = '0;
        p1_bus_in = '0;

        test_reset();
        test_write();
        test_addr_hold();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_tph1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 SHALL have parameter T_PH, default 4, clocks per bus phase, legal range 1..15.
REQ-002 SHALL have parameter N, default 8, bus and data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester request; bit0 = CPU, bit1 = refresh scanner.
REQ-006 SHALL have port we  input  2  per-requester write (1) or read (0).
REQ-007 SHALL have port addr  input  2N  {addr1, addr0}, RTC register address.
REQ-008 SHALL have port wdata  input  2N  {wdata1, wdata0}, write data.
REQ-009 SHALL have port gnt  output  2  one-hot grant, held for the whole transaction.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  N  last read result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports AD, CS, WR, RD  output  1 each  active-low RTC bus strobes; AD low marks the address phase.
REQ-014 SHALL have port bus_out  output  N  value driven on the RTC data/address bus.
REQ-015 SHALL have port bus_oe  output  1  bus driver enable.
REQ-016 SHALL have port bus_in  input  N  value sampled from the RTC bus.

Function
REQ-017 SHALL implement states IDLE, ADR, ADR_H, DAT, DAT_H, DONE, with a 4-bit phase counter.
REQ-018 In IDLE with any req bit high, the arbiter SHALL, on the next edge, enter ADR and assert the selected gnt bit.
REQ-019 At the grant edge, the arbiter SHALL latch the winner's addr, wdata and we; later changes to requester inputs SHALL NOT affect the transaction.
REQ-020 Arbitration SHALL be round-robin: if both requesters request, the one not granted last wins; after reset, requester 0 wins first.
REQ-021 ADR, ADR_H, DAT and DAT_H SHALL each last exactly T_PH cycles, then advance in that order; DONE SHALL last 1 cycle, then the arbiter SHALL return to IDLE.
REQ-022 ADR outputs: AD=0, CS=0, WR=0, RD=1, bus_oe=1, bus_out=latched addr.
REQ-023 ADR_H outputs: AD=1, CS=1, WR=1, RD=1, bus_oe=0 (turnaround).
REQ-024 DAT outputs: AD=1, CS=0. For a write: WR=0, RD=1, bus_oe=1, bus_out=latched wdata. For a read: WR=1, RD=0, bus_oe=0.
REQ-025 For a read, rdata SHALL capture bus_in on the last clock of DAT; a write SHALL leave rdata unchanged.
REQ-026 DAT_H, DONE and IDLE outputs: AD=CS=WR=RD=1, bus_oe=0.
REQ-027 done SHALL be 1 only in DONE; gnt SHALL remain set through DONE and clear on the edge that enters IDLE.
REQ-028 done SHALL assert exactly 4*T_PH cycles after gnt rises.
REQ-029 req is sampled only in IDLE. A req still high after done SHALL start a new transaction, subject to round-robin; the minimum gap between transactions is one IDLE cycle.
REQ-030 WR and RD SHALL never be low simultaneously; bus_oe SHALL never be 1 while RD=0.

Reset
REQ-031 While reset=0, independent of clk, the block SHALL hold state=IDLE, gnt=00, done=0, busy=0, AD=CS=WR=RD=1, bus_oe=0, bus_out=0, rdata=0, round-robin last=1, counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no done pulse. After release, a pending req SHALL start a fresh transaction from ADR.

Verification
REQ-033 Single write, T_PH=4, req=01, we=01, addr0=0x21, wdata0=0x45:
- gnt=01 one cycle later.
- 4 cycles of AD/CS/WR=0 with bus_out=0x21, then 4 cycles of all strobes high.
- 4 cycles of CS/WR=0, AD=1, bus_out=0x45; RD stays 1 throughout.
- done 16 cycles after gnt.
REQ-034 Single read, req=10, we=00, addr1=0x33, bus_in=0x59 during DAT:
- RD=0 and bus_oe=0 for 4 cycles.
- rdata=0x59 when done=1; gnt=10.
REQ-035 Simultaneous req=11 held continuously after reset: grants SHALL be 01, 10, 01, 10, separated by one IDLE cycle each.
REQ-036 reset driven low during DAT of a write:
- Same cycle: strobes=1, bus_oe=0, gnt=00, no done.
- After release with req=01 held: gnt=01 next cycle, restarting at ADR.
REQ-037 T_PH=1, write: each phase lasts 1 cycle; done 4 cycles after gnt.
REQ-038 addr0 changed 0x21->0x7F during ADR: bus_out SHALL stay 0x21 for the full ADR phase.
